// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg -- shared video definitions for the pixel pipeline.
//
// Holds the colour width, the coordinate widths, the blank colour and the
// small types that pixel-stage blocks pass around. It also holds the
// span-compare helper that rectangle overlays use.
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int RGB_W = 12;          // {r,g,b}, 4 bits each
  localparam int CNT_W = 11;          // hcount / vcount from the timing generator
  localparam int POS_W = 12;          // object position registers
  localparam int SUM_W = POS_W + 1;   // position + size without wrap-around

  localparam logic [RGB_W-1:0] BLANK_RGB = 12'h000;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [POS_W-1:0] pos_t;

  // One pixel's worth of timing information, carried down the pipeline.
  typedef struct packed {
    cnt_t hcount;
    cnt_t vcount;
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } timing_t;

  // Frame-latched configuration of one rectangle channel.
  typedef struct packed {
    logic en;
    pos_t xpos;
    pos_t ypos;
    rgb_t rgb;
  } rect_cfg_t;

  // True when start <= coord < start + len. Everything is widened to SUM_W
  // so a rectangle near position 4095 runs off the end of the coordinate
  // space instead of wrapping back onto column/row 0.
  function automatic logic in_span(input cnt_t coord,
                                   input pos_t start,
                                   input logic [SUM_W-1:0] len);
    logic [SUM_W-1:0] c;
    logic [SUM_W-1:0] lo;
    logic [SUM_W-1:0] hi;
    c  = SUM_W'(coord);
    lo = SUM_W'(start);
    hi = lo + len;
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/rect_hit.sv
// ---------------------------------------------------------------------------
// rect_hit -- bounds compare for one fixed-size rectangle channel.
//
// Purely combinational; the parent registers the result.
//
// Parameters
//   RECT_W, RECT_H : rectangle size in pixels
// Ports
//   hcount, vcount : current pixel position (11 bits)
//   xpos, ypos     : top-left corner of the rectangle (12 bits)
//   en             : channel enable
//   hit            : pixel lies inside the enabled rectangle
// ---------------------------------------------------------------------------
module rect_hit
  import vga_pkg::*;
#(
  parameter int RECT_W = 48,
  parameter int RECT_H = 64
) (
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  input  logic             en,
  output logic             hit
);

  localparam logic [SUM_W-1:0] SPAN_W = SUM_W'(RECT_W);
  localparam logic [SUM_W-1:0] SPAN_H = SUM_W'(RECT_H);

  assign hit = en
            && in_span(hcount, xpos, SPAN_W)
            && in_span(vcount, ypos, SPAN_H);

endmodule

// File: rtl/draw_rect_multi.sv
// ---------------------------------------------------------------------------
// draw_rect_multi -- overlays up to eight fixed-size filled rectangles on the
// incoming pixel stream.
//
// Pipeline (2 pclk latency for every count, strobe and colour):
//   stage 1 : per-channel bounds compare -> registered hit vector, plus the
//             delayed timing, background and channel colours
//   stage 2 : lowest-index hit wins; blanking forces 12'h000
//
// Channel positions, enables and colours are copied into active registers
// only in the cycle after vblnk_in rises, so changes made mid-frame never
// tear the picture. frame_latch pulses for the one cycle in which those
// active registers present the freshly loaded values.
//
// Parameters
//   N_RECT         : number of channels (1..8)
//   RECT_W, RECT_H : rectangle size in pixels
// Ports
//   pclk, rst                  : pixel clock, async active-high reset
//   hcount_in, vcount_in       : upstream pixel position
//   hsync_in .. vblnk_in       : upstream timing strobes
//   rgb_in                     : background pixel
//   xpos, ypos                 : per-channel corner, channel i at [12i+11:12i]
//   rect_en, rect_rgb          : per-channel enable and fill colour
//   hcount_out .. vblnk_out    : timing delayed by 2 cycles
//   rgb_out                    : composited pixel
//   frame_latch                : one-cycle pulse on active-register reload
// ---------------------------------------------------------------------------
module draw_rect_multi
  import vga_pkg::*;
#(
  parameter int N_RECT = 4,
  parameter int RECT_W = 48,
  parameter int RECT_H = 64
) (
  input  logic                      pclk,
  input  logic                      rst,

  input  logic [CNT_W-1:0]          hcount_in,
  input  logic [CNT_W-1:0]          vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblnk_in,
  input  logic                      vblnk_in,
  input  logic [RGB_W-1:0]          rgb_in,

  input  logic [POS_W*N_RECT-1:0]   xpos,
  input  logic [POS_W*N_RECT-1:0]   ypos,
  input  logic [N_RECT-1:0]         rect_en,
  input  logic [RGB_W*N_RECT-1:0]   rect_rgb,

  output logic [CNT_W-1:0]          hcount_out,
  output logic [CNT_W-1:0]          vcount_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblnk_out,
  output logic                      vblnk_out,
  output logic [RGB_W-1:0]          rgb_out,
  output logic                      frame_latch
);

  // -------------------------------------------------------------------------
  // Frame-synchronous load of the channel registers
  // -------------------------------------------------------------------------
  rect_cfg_t [N_RECT-1:0] active;
  logic                   vblnk_prev;
  logic                   load_req;

  // vblnk_prev resets high: a vblnk already asserted when reset is released
  // is not a rising edge, so nothing is drawn until a genuine vblank start.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_prev  <= 1'b1;
      load_req    <= 1'b0;
      frame_latch <= 1'b0;
      // NOTE: the active copies are reset, not left undefined, so every
      // channel is disabled until the first frame load after reset.
      active      <= '0;
    end else begin
      // NOTE: non-blocking assignments, so load_req and frame_latch each see
      // the value their source held before this edge.
      vblnk_prev  <= vblnk_in;
      load_req    <= vblnk_in & ~vblnk_prev;
      frame_latch <= load_req;
      if (load_req) begin
        for (int i = 0; i < N_RECT; i++) begin
          active[i].en   <= rect_en[i];
          active[i].xpos <= xpos[POS_W*i +: POS_W];
          active[i].ypos <= ypos[POS_W*i +: POS_W];
          active[i].rgb  <= rect_rgb[RGB_W*i +: RGB_W];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: bounds compare per channel
  // -------------------------------------------------------------------------
  logic [N_RECT-1:0]            hit_comb;
  logic [N_RECT-1:0]            hit_q;
  logic [N_RECT-1:0][RGB_W-1:0] col_q;
  timing_t                      tim_in;
  timing_t                      tim_q;
  logic [RGB_W-1:0]             rgb_q;

  for (genvar i = 0; i < N_RECT; i++) begin : g_hit
    rect_hit #(
      .RECT_W (RECT_W),
      .RECT_H (RECT_H)
    ) u_rect_hit (
      .hcount (hcount_in),
      .vcount (vcount_in),
      .xpos   (active[i].xpos),
      .ypos   (active[i].ypos),
      .en     (active[i].en),
      .hit    (hit_comb[i])
    );
  end

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in,
                    hsync:  hsync_in,  vsync:  vsync_in,
                    hblnk:  hblnk_in,  vblnk:  vblnk_in};

  // The channel colours travel with the hit vector so that a reload landing
  // between stage 1 and stage 2 cannot pair an old position with a new colour.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
      col_q <= '0;
      tim_q <= '0;
      rgb_q <= '0;
    end else begin
      hit_q <= hit_comb;
      tim_q <= tim_in;
      rgb_q <= rgb_in;
      for (int i = 0; i < N_RECT; i++) begin
        col_q[i] <= active[i].rgb;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: priority select and blanking
  // -------------------------------------------------------------------------
  logic [RGB_W-1:0] rgb_sel;

  // Scanning from the highest index down lets the lowest-index hit be the
  // last one written, which gives it priority.
  always_comb begin
    // NOTE: default assignment first so no latch is inferred when no
    // channel hits.
    rgb_sel = rgb_q;
    for (int i = N_RECT-1; i >= 0; i--) begin
      if (hit_q[i]) begin
        rgb_sel = col_q[i];
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= tim_q.hcount;
      vcount_out <= tim_q.vcount;
      hsync_out  <= tim_q.hsync;
      vsync_out  <= tim_q.vsync;
      hblnk_out  <= tim_q.hblnk;
      vblnk_out  <= tim_q.vblnk;
      rgb_out    <= (tim_q.hblnk || tim_q.vblnk) ? BLANK_RGB : rgb_sel;
    end
  end

endmodule

// File: tb/tb_draw_rect_multi.sv
// ---------------------------------------------------------------------------
// tb_draw_rect_multi -- self-checking bench for draw_rect_multi.
//
// One pixel is presented per clock, in any order the test chooses. A
// reference model computes each pixel's expected output straight from the
// drawing rules and the frame-load rule, and queues it; outputs are compared
// two cycles later on the falling edge.
// ---------------------------------------------------------------------------
module tb_draw_rect_multi;

  localparam int N = 4;
  localparam int W = 48;
  localparam int H = 64;

  logic               pclk = 1'b0;
  logic               rst;
  logic [10:0]        hcount_in, vcount_in;
  logic               hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]        rgb_in;
  logic [12*N-1:0]    xpos, ypos, rect_rgb;
  logic [N-1:0]       rect_en;
  logic [10:0]        hcount_out, vcount_out;
  logic               hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]        rgb_out;
  logic               frame_latch;

  draw_rect_multi #(.N_RECT(N), .RECT_W(W), .RECT_H(H)) dut (
    .pclk        (pclk),
    .rst         (rst),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .hblnk_in    (hblnk_in),
    .vblnk_in    (vblnk_in),
    .rgb_in      (rgb_in),
    .xpos        (xpos),
    .ypos        (ypos),
    .rect_en     (rect_en),
    .rect_rgb    (rect_rgb),
    .hcount_out  (hcount_out),
    .vcount_out  (vcount_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .hblnk_out   (hblnk_out),
    .vblnk_out   (vblnk_out),
    .rgb_out     (rgb_out),
    .frame_latch (frame_latch)
  );

  always #5 pclk = ~pclk;

  // Configuration currently presented on the channel inputs.
  int          cfg_x [N];
  int          cfg_y [N];
  bit          cfg_en[N];
  logic [11:0] cfg_c [N];

  // Model of the frame-latched configuration.
  int          act_x [N];
  int          act_y [N];
  bit          act_en[N];
  logic [11:0] act_c [N];
  bit          m_prev_vb;
  bit          m_pending;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb, logic [11:0] bg);
    if (hb || vb) return 12'h000;
    for (int i = 0; i < N; i++)
      if (act_en[i] && h >= act_x[i] && h < act_x[i] + W &&
          v >= act_y[i] && v < act_y[i] + H)
        return act_c[i];
    return bg;
  endfunction

  function automatic exp_t zero_rec();
    exp_t e;
    e = '{h: 11'd0, v: 11'd0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: 12'h000, fl: 1'b0};
    return e;
  endfunction

  // After reset the outputs hold zero for two cycles while the pipeline refills.
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      act_x[i] = 0; act_y[i] = 0; act_en[i] = 0; act_c[i] = 12'h000;
    end
    m_prev_vb = 1'b1;
    m_pending = 1'b0;
    exp_q.delete();
    exp_q.push_back(zero_rec());
    exp_q.push_back(zero_rec());
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("rgb_out", 64'(rgb_out), 64'(e.rgb));
      check("frame_latch", 64'(frame_latch), 64'(e.fl));
      check("timing", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                      64'({e.h, e.v, e.hs, e.vs, e.hb, e.vb}));
    end
  endtask

  function automatic logic [38:0] all_outputs();
    return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, frame_latch};
  endfunction

  // Present one pixel for one clock and record what should come out of it.
  task automatic pixel(input int h, input int v, input bit hb, input bit vb, input logic [11:0] bg);
    exp_t e;
    compare_outputs();
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = bg;
    for (int i = 0; i < N; i++) begin
      xpos[12*i +: 12]     = 12'(cfg_x[i]);
      ypos[12*i +: 12]     = 12'(cfg_y[i]);
      rect_en[i]           = cfg_en[i];
      rect_rgb[12*i +: 12] = cfg_c[i];
    end
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.hb  = hb;
    e.vb  = vb;
    e.rgb = model_rgb(h, v, hb, vb, bg);
    e.fl  = vb && !m_prev_vb;
    // The cycle after a vblank rising edge takes whatever is on the inputs now.
    if (m_pending) begin
      for (int i = 0; i < N; i++) begin
        act_x[i] = cfg_x[i]; act_y[i] = cfg_y[i]; act_en[i] = cfg_en[i]; act_c[i] = cfg_c[i];
      end
    end
    m_pending = vb && !m_prev_vb;
    m_prev_vb = vb;
    exp_q.push_back(e);
    @(negedge pclk);
  endtask

  task automatic vblank_gap(input logic [11:0] bg);
    for (int k = 0; k < 4; k++) pixel(0, 600 + k, 1'b1, 1'b1, bg);
    pixel(0, 0, 1'b0, 1'b0, bg);
    pixel(1, 0, 1'b0, 1'b0, bg);
  endtask

  task automatic set_ch(input int i, input bit en, input int x, input int y, input logic [11:0] c);
    cfg_en[i] = en; cfg_x[i] = x; cfg_y[i] = y; cfg_c[i] = c;
  endtask

  task automatic flush(input logic [11:0] bg);
    pixel(5, 5, 1'b1, 1'b0, bg);
    pixel(6, 5, 1'b1, 1'b0, bg);
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in = '0; xpos = '0; ypos = '0; rect_en = '0; rect_rgb = '0;
    for (int i = 0; i < N; i++) set_ch(i, 1'b0, 0, 0, 12'h000);

    // Reset state.
    repeat (3) @(negedge pclk);
    check("reset_outputs", 64'(all_outputs()), 64'd0);
    rst = 1'b0;
    model_reset();

    // Single rectangle on channel 0.
    set_ch(0, 1'b1, 100, 50, 12'hF00);
    pixel(100, 50, 1'b0, 1'b0, 12'h0F0);     // before any vblank: nothing drawn
    vblank_gap(12'h0F0);
    pixel(100, 50,  1'b0, 1'b0, 12'h0F0);
    pixel(147, 113, 1'b0, 1'b0, 12'h0F0);
    pixel(148, 50,  1'b0, 1'b0, 12'h0F0);
    pixel(100, 114, 1'b0, 1'b0, 12'h0F0);
    pixel(99, 50,   1'b0, 1'b0, 12'h0F0);
    pixel(100, 49,  1'b0, 1'b0, 12'h0F0);

    // Overlap: channel 0 outranks channel 1.
    set_ch(1, 1'b1, 120, 60, 12'h00F);
    vblank_gap(12'h0F0);
    pixel(130, 70, 1'b0, 1'b0, 12'h0F0);
    pixel(160, 70, 1'b0, 1'b0, 12'h0F0);
    pixel(167, 70, 1'b0, 1'b0, 12'h0F0);
    pixel(168, 70, 1'b0, 1'b0, 12'h0F0);

    // Mid-frame move is held off until the next frame load.
    set_ch(0, 1'b1, 300, 50, 12'hF00);
    pixel(100, 50, 1'b0, 1'b0, 12'h0F0);
    pixel(300, 50, 1'b0, 1'b0, 12'h0F0);
    vblank_gap(12'h0F0);
    pixel(100, 50, 1'b0, 1'b0, 12'h0F0);
    pixel(300, 50, 1'b0, 1'b0, 12'h0F0);

    // Change coinciding with the vblank edge: the load cycle's values win.
    pixel(0, 600, 1'b1, 1'b1, 12'h0F0);
    set_ch(0, 1'b1, 400, 50, 12'hF0F);
    pixel(0, 601, 1'b1, 1'b1, 12'h0F0);
    set_ch(0, 1'b1, 500, 50, 12'h0FF);
    pixel(0, 0, 1'b0, 1'b0, 12'h0F0);
    pixel(400, 50, 1'b0, 1'b0, 12'h0F0);
    pixel(500, 50, 1'b0, 1'b0, 12'h0F0);

    // Right-edge clip and no wrap from the top of the position range.
    set_ch(2, 1'b1, 780, 0, 12'h0AA);
    set_ch(3, 1'b1, 4090, 0, 12'h555);
    vblank_gap(12'h123);
    for (int h = 776; h < 804; h++) pixel(h, 0, h >= 800, 1'b0, 12'h123);
    for (int h = 0; h <= 10; h++) pixel(h, 1, 1'b0, 1'b0, 12'h123);
    set_ch(3, 1'b1, 4095, 4095, 12'h555);
    vblank_gap(12'h123);
    for (int h = 0; h <= 3; h++) pixel(h, 0, 1'b0, 1'b0, 12'h123);

    // Blanking inside a rectangle.
    set_ch(0, 1'b1, 100, 50, 12'hF00);
    vblank_gap(12'h0F0);
    pixel(110, 60, 1'b1, 1'b0, 12'h0F0);
    pixel(111, 60, 1'b0, 1'b0, 12'h0F0);
    pixel(112, 60, 1'b1, 1'b0, 12'h0F0);

    // Randomised frames, positions and mid-frame edits.
    for (int n = 0; n < 4000; n++) begin
      bit          vb;
      int          h, v;
      logic [11:0] bg;
      vb = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 29) == 0 || (vb && $urandom_range(0, 1) == 0)) begin
        int ch;
        int x, y;
        ch = $urandom_range(0, N-1);
        x  = ($urandom_range(0, 9) == 0) ? $urandom_range(4000, 4095) : $urandom_range(0, 250);
        y  = ($urandom_range(0, 9) == 0) ? $urandom_range(4000, 4095) : $urandom_range(0, 250);
        set_ch(ch, 1'($urandom_range(0, 3) != 0), x, y, 12'($urandom));
      end
      h  = $urandom_range(0, 320);
      v  = $urandom_range(0, 320);
      bg = 12'($urandom);
      pixel(h, v, ($urandom_range(0, 15) == 0), vb, bg);
    end

    // Reset in the middle of a line: outputs clear without waiting for a clock.
    set_ch(0, 1'b1, 100, 50, 12'hF00);
    vblank_gap(12'h0F0);
    pixel(120, 60, 1'b0, 1'b0, 12'h0F0);
    pixel(121, 60, 1'b0, 1'b0, 12'h0F0);
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 64'(all_outputs()), 64'd0);
    @(negedge pclk);
    check("reset_hold", 64'(all_outputs()), 64'd0);
    rst = 1'b0;
    model_reset();
    pixel(120, 60, 1'b0, 1'b0, 12'h0F0);      // rectangle gone until a vblank
    pixel(130, 70, 1'b0, 1'b0, 12'h0F0);
    pixel(140, 80, 1'b0, 1'b0, 12'h0F0);
    vblank_gap(12'h0F0);
    pixel(120, 60, 1'b0, 1'b0, 12'h0F0);
    flush(12'h0F0);
    compare_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
